audioqsys_keys_in: RTL and testbench

//  Avalon-MM slave input PIO for the push-keys; read-side counterpart of the LED output PIOs.

---
 rtl/audioqsys_keys_in.sv | 85 ++++++++
 tb/tb_audioqsys_keys_in.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/audioqsys_keys_in.sv
// audioqsys_keys_in: Avalon-MM key input PIO with synchroniser, debounce, sticky edge capture and level IRQ
module audioqsys_keys_in #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]         sync1_q, sync2_q;
  logic [WIDTH-1:0]         db_q, db_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         irqmask_q, irqmask_d;
  logic [WIDTH-1:0]         edgecapture_q, edgecapture_d;
  logic [WIDTH-1:0]         rise, fall, set, clr, rd_sel;
  logic                     wr;
  logic                     unused_wd;

  assign unused_wd = ^writedata;

  // Two-flop synchroniser, kept free of logic so both stages sit back to back
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end

  // Per-bit debounce: a bit only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++)
      if (sync2_q[i] == db_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else cnt_d[i] = cnt_q[i] + CW'(1);
  end

  // Edge capture is keyed off the debounced update itself; a new edge beats a same-cycle clear
  always_comb begin
    wr            = chipselect & ~write_n;
    rise          = db_d & ~db_q;
    fall          = ~db_d & db_q;
    set           = EDGE_TYPE == 0 ? rise : EDGE_TYPE == 1 ? fall : rise | fall;
    clr           = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    irqmask_d     = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
    edgecapture_d = (edgecapture_q & ~clr) | set;
  end

  // Debounce, mask and capture state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      db_q          <= RESET_LEVEL;
      cnt_q         <= '0;
      irqmask_q     <= '0;
      edgecapture_q <= '0;
    end else begin
      db_q          <= db_d;
      cnt_q         <= cnt_d;
      irqmask_q     <= irqmask_d;
      edgecapture_q <= edgecapture_d;
    end

  // Zero-latency read mux and level interrupt, both purely from registers
  always_comb begin
    rd_sel   = address == 2'd0 ? db_q : address == 2'd2 ? irqmask_q : address == 2'd3 ? edgecapture_q : '0;
    readdata = 32'(rd_sel);
    irq      = |(edgecapture_q & irqmask_q);
  end
endmodule

// File: tb/tb_audioqsys_keys_in.sv
// tb_audioqsys_keys_in: scoreboard bench for the key input PIO (falling-edge and any-edge instances)
module tb_audioqsys_keys_in;
  logic        clk = 0, reset_n = 0;
  logic [1:0]  address = 0;
  logic        chipselect = 0, write_n = 1;
  logic [31:0] writedata = 0;
  logic [3:0]  in_port = 4'hF, in_port2 = 4'hF;
  logic [31:0] readdata, readdata2;
  logic        irq, irq2;
  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  audioqsys_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(readdata), .irq(irq));

  audioqsys_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port2), .readdata(readdata2), .irq(irq2));

  task automatic rd(input logic [1:0] a, input bit second, output logic [31:0] d);
    address = a; chipselect = 1; write_n = 1;
    #1 d = second ? readdata2 : readdata;
    chipselect = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    address = a; chipselect = 1; write_n = 0; writedata = v;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask

  task automatic test_reset();
    logic [31:0] d, e, obs[$]; string nm[$];
    repeat (3) @(negedge clk);
    exp_q.push_back(32'hF); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    rd(0, 0, d); obs.push_back(d); nm.push_back("reset_data");
    rd(2, 0, d); obs.push_back(d); nm.push_back("reset_irqmask");
    rd(3, 0, d); obs.push_back(d); nm.push_back("reset_edgecap");
    obs.push_back(32'(irq)); nm.push_back("reset_irq");
    @(negedge clk) reset_n = 1;
    foreach (obs[i]) begin
      e = exp_q.pop_front(); checks++;
      if (obs[i] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm[i], obs[i], e); end
    end
  endtask

  task automatic test_latency();
    logic [31:0] d, e, obs[$]; string nm[$];
    @(negedge clk) in_port = 4'hE;
    exp_q.push_back(32'hF); exp_q.push_back(0);
    exp_q.push_back(32'hE); exp_q.push_back(32'h1); exp_q.push_back(0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rd(0, 0, d); obs.push_back(d); nm.push_back("lat_data_before");
    rd(3, 0, d); obs.push_back(d); nm.push_back("lat_edgecap_before");
    @(negedge clk);
    rd(0, 0, d); obs.push_back(d); nm.push_back("lat_data_after");
    rd(3, 0, d); obs.push_back(d); nm.push_back("lat_edgecap_after");
    obs.push_back(32'(irq)); nm.push_back("lat_irq_masked");
    foreach (obs[i]) begin
      e = exp_q.pop_front(); checks++;
      if (obs[i] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm[i], obs[i], e); end
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d, e, obs[$]; string nm[$];
    @(negedge clk) in_port = 4'hC;
    repeat (3) @(negedge clk);
    in_port = 4'hE;
    exp_q.push_back(32'hE); exp_q.push_back(32'h1);
    repeat (10) @(negedge clk);
    rd(0, 0, d); obs.push_back(d); nm.push_back("glitch_data");
    rd(3, 0, d); obs.push_back(d); nm.push_back("glitch_edgecap");
    foreach (obs[i]) begin
      e = exp_q.pop_front(); checks++;
      if (obs[i] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm[i], obs[i], e); end
    end
  endtask

  task automatic test_irq();
    logic [31:0] d, e, obs[$]; string nm[$];
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(32'h1); exp_q.push_back(0); exp_q.push_back(0);
    obs.push_back(32'(irq)); nm.push_back("irq_before_mask");
    wr(2, 32'h1);
    obs.push_back(32'(irq)); nm.push_back("irq_after_mask");
    rd(2, 0, d); obs.push_back(d); nm.push_back("irqmask_read");
    wr(3, 32'h1);
    obs.push_back(32'(irq)); nm.push_back("irq_after_clear");
    rd(3, 0, d); obs.push_back(d); nm.push_back("edgecap_after_clear");
    foreach (obs[i]) begin
      e = exp_q.pop_front(); checks++;
      if (obs[i] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm[i], obs[i], e); end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d, e, obs[$]; string nm[$];
    wr(0, 32'h0);
    wr(1, 32'hF);
    wr(2, 32'hFFFF_FFFF);
    exp_q.push_back(32'hE); exp_q.push_back(0); exp_q.push_back(32'hF);
    rd(0, 0, d); obs.push_back(d); nm.push_back("data_write_ignored");
    rd(1, 0, d); obs.push_back(d); nm.push_back("reserved_read");
    rd(2, 0, d); obs.push_back(d); nm.push_back("irqmask_upper_zero");
    wr(2, 32'h1);
    foreach (obs[i]) begin
      e = exp_q.pop_front(); checks++;
      if (obs[i] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm[i], obs[i], e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e, obs[$]; string nm[$];
    @(negedge clk) in_port = 4'hF;
    exp_q.push_back(32'hF); exp_q.push_back(0); exp_q.push_back(0);
    repeat (10) @(negedge clk);
    rd(0, 0, d); obs.push_back(d); nm.push_back("rise_data");
    rd(3, 0, d); obs.push_back(d); nm.push_back("rise_not_captured");
    obs.push_back(32'(irq)); nm.push_back("rise_irq");
    @(negedge clk) in_port = 4'hE;
    exp_q.push_back(32'h1); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    repeat (5) @(posedge clk);
    wr(3, 32'h1);
    rd(3, 0, d); obs.push_back(d); nm.push_back("set_beats_clear");
    obs.push_back(32'(irq)); nm.push_back("set_beats_clear_irq");
    wr(3, 32'h1);
    rd(3, 0, d); obs.push_back(d); nm.push_back("later_clear");
    obs.push_back(32'(irq)); nm.push_back("later_clear_irq");
    foreach (obs[i]) begin
      e = exp_q.pop_front(); checks++;
      if (obs[i] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm[i], obs[i], e); end
    end
  endtask

  task automatic test_any_edge_reset();
    logic [31:0] d, e, obs[$]; string nm[$];
    @(negedge clk) in_port2 = 4'hB;
    exp_q.push_back(32'h4); exp_q.push_back(32'h4); exp_q.push_back(1);
    repeat (10) @(negedge clk);
    rd(3, 1, d); obs.push_back(d); nm.push_back("any_press");
    wr(3, 32'h4);
    @(negedge clk) in_port2 = 4'hF;
    repeat (10) @(negedge clk);
    rd(3, 1, d); obs.push_back(d); nm.push_back("any_release");
    wr(2, 32'h4);
    obs.push_back(32'(irq2)); nm.push_back("any_irq");
    @(negedge clk) in_port2 = 4'hB;
    exp_q.push_back(32'hF); exp_q.push_back(32'hF); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    repeat (2) @(posedge clk);
    #2 reset_n = 0;
    rd(0, 0, d); obs.push_back(d); nm.push_back("rst_dut1_data");
    rd(0, 1, d); obs.push_back(d); nm.push_back("rst_dut2_data");
    rd(3, 1, d); obs.push_back(d); nm.push_back("rst_dut2_edgecap");
    rd(2, 1, d); obs.push_back(d); nm.push_back("rst_dut2_irqmask");
    obs.push_back(32'(irq2)); nm.push_back("rst_irq2");
    obs.push_back(32'(irq)); nm.push_back("rst_irq1");
    @(negedge clk) in_port2 = 4'hF;
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (10) @(negedge clk);
    rd(3, 1, d); obs.push_back(d); nm.push_back("no_capture_on_release");
    foreach (obs[i]) begin
      e = exp_q.pop_front(); checks++;
      if (obs[i] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm[i], obs[i], e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_irq();
    test_regs();
    test_back_to_back();
    test_any_edge_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
